// File: rtl/ifsram_port_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifsram_port_arb_if
//  Description : Bundle of the three requester channels (pad writer, row
//                writer, row reader), the single-port SRAM side and the
//                arbitration status that the ifsram port arbiter uses.
//                  slave  : arbiter view (takes requests, drives grants/SRAM)
//                  master : requester/SRAM view (drives requests, read data)
//  Signals     : pad_* / wr_*  req, last, addr, data in; gnt out
//                rd_*          req, last, addr in; gnt, data, valid out
//                sram_*        cen, wen, addr, wdata out; rdata in
//                arb_owner     0=none 1=pad 2=wr 3=rd
//  Revision    : 1.0  initial release
// ============================================================================
interface ifsram_port_arb_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64
);
    logic              pad_req;
    logic              pad_last;
    logic [ADDR_W-1:0] pad_addr;
    logic [DATA_W-1:0] pad_data;
    logic              pad_gnt;

    logic              wr_req;
    logic              wr_last;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              rd_req;
    logic              rd_last;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic [1:0]        arb_owner;

    modport slave (
        input  pad_req, pad_last, pad_addr, pad_data,
        input  wr_req, wr_last, wr_addr, wr_data,
        input  rd_req, rd_last, rd_addr,
        input  sram_rdata,
        output pad_gnt, wr_gnt, rd_gnt, rd_data, rd_valid,
        output sram_cen, sram_wen, sram_addr, sram_wdata,
        output arb_owner
    );

    modport master (
        output pad_req, pad_last, pad_addr, pad_data,
        output wr_req, wr_last, wr_addr, wr_data,
        output rd_req, rd_last, rd_addr,
        output sram_rdata,
        input  pad_gnt, wr_gnt, rd_gnt, rd_data, rd_valid,
        input  sram_cen, sram_wen, sram_addr, sram_wdata,
        input  arb_owner
    );
endinterface
`default_nettype wire

// File: rtl/ifsram_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ifsram_port_arb
//  Description : Round-robin burst arbiter for the single ifsram port shared
//                by the pad writer, row writer and row reader. A grant covers
//                a whole burst; the burst ends on a beat with last, on the
//                MAX_BURST-th beat, or when the owner drops its request.
//                Every burst is followed by at least one idle cycle, which
//                doubles as the SRAM read/write turnaround.
//  Ports       : clk        clock
//                reset      synchronous, active-high reset
//                bus        ifsram_port_arb_if.slave
//                             requester req/last/addr/data in, gnt out
//                             rd_data/rd_valid read return out
//                             sram_cen/wen/addr/wdata out, sram_rdata in
//                             arb_owner out (0=none 1=pad 2=wr 3=rd)
//  Parameters  : ADDR_W     SRAM word address width
//                DATA_W     SRAM data width
//                MAX_BURST  beats per grant before forced release (>=1)
//  Revision    : 1.0  initial release
// ============================================================================
module ifsram_port_arb #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    ifsram_port_arb_if.slave   bus
);

    localparam int                CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  C_MAX_BURST = CNT_W'(MAX_BURST);

    // Owner codes double as arb_owner values and round-robin pointer values.
    localparam logic [1:0] C_OWN_NONE = 2'd0;
    localparam logic [1:0] C_OWN_PAD  = 2'd1;
    localparam logic [1:0] C_OWN_WR   = 2'd2;
    localparam logic [1:0] C_OWN_RD   = 2'd3;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    arb_state_t        state_q;
    logic [1:0]        owner_q;
    logic              pad_gnt_q;
    logic              wr_gnt_q;
    logic              rd_gnt_q;
    logic [1:0]        rr_ptr_q;      // highest-priority requester in IDLE
    logic [CNT_W-1:0]  beat_cnt_q;

    logic              rd_valid_q;
    logic [ADDR_W-1:0] sram_addr_q;   // last address driven to the SRAM
    logic [DATA_W-1:0] sram_wdata_q;  // last write data driven to the SRAM
    logic [DATA_W-1:0] rd_data_q;     // last returned read word

    logic [ADDR_W-1:0] sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_d;
    logic [DATA_W-1:0] rd_data_d;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic              w_own_req;
    logic              w_own_last;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_data;
    logic              w_beat;
    logic              w_wr_beat;
    logic              w_rd_beat;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_burst_end;
    logic [1:0]        w_winner;

    // First requester at or after ptr in the cyclic order pad -> wr -> rd.
    // req[0]=pad, req[1]=wr, req[2]=rd.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
        logic [1:0] cand;
        logic [1:0] pick;
        cand = ptr;
        pick = C_OWN_NONE;
        for (int i = 0; i < 3; i++) begin
            if (pick == C_OWN_NONE) begin
                unique case (cand)
                    C_OWN_PAD: if (req[0]) pick = C_OWN_PAD;
                    C_OWN_WR:  if (req[1]) pick = C_OWN_WR;
                    C_OWN_RD:  if (req[2]) pick = C_OWN_RD;
                    default:   ;
                endcase
            end
            cand = (cand == C_OWN_RD) ? C_OWN_PAD : cand + 2'd1;
        end
        return pick;
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] own);
        return (own == C_OWN_RD) ? C_OWN_PAD : own + 2'd1;
    endfunction

    // Only the owner's channel is ever looked at; with no owner nothing
    // qualifies as a beat and the SRAM-side values stay parked.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_addr = sram_addr_q;
        w_own_data = sram_wdata_q;
        case (owner_q)
            C_OWN_PAD: begin
                w_own_req  = bus.pad_req;
                w_own_last = bus.pad_last;
                w_own_addr = bus.pad_addr;
                w_own_data = bus.pad_data;
            end
            C_OWN_WR: begin
                w_own_req  = bus.wr_req;
                w_own_last = bus.wr_last;
                w_own_addr = bus.wr_addr;
                w_own_data = bus.wr_data;
            end
            C_OWN_RD: begin
                w_own_req  = bus.rd_req;
                w_own_last = bus.rd_last;
                w_own_addr = bus.rd_addr;
            end
            default: ;
        endcase
    end

    // owner_q is non-zero only in ARB_OWN, and then exactly its gnt is high.
    assign w_beat      = w_own_req;
    assign w_wr_beat   = w_beat && (owner_q != C_OWN_RD);
    assign w_rd_beat   = w_beat && (owner_q == C_OWN_RD);
    assign w_cnt_inc   = beat_cnt_q + CNT_W'(1);
    assign w_burst_end = !w_beat || w_own_last || (w_cnt_inc == C_MAX_BURST);
    assign w_winner    = rr_pick(rr_ptr_q, {bus.rd_req, bus.wr_req, bus.pad_req});

    // ------------------------------------------------------------------------
    // Arbitration FSM with registered grants
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= C_OWN_NONE;
            pad_gnt_q  <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            rr_ptr_q   <= C_OWN_PAD;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (w_winner != C_OWN_NONE) begin
                        state_q   <= ARB_OWN;
                        owner_q   <= w_winner;
                        pad_gnt_q <= (w_winner == C_OWN_PAD);
                        wr_gnt_q  <= (w_winner == C_OWN_WR);
                        rd_gnt_q  <= (w_winner == C_OWN_RD);
                    end
                end
                ARB_OWN: begin
                    if (w_burst_end) begin
                        // Returning to IDLE for one cycle gives the turnaround
                        // gap; the released owner drops to lowest priority.
                        state_q    <= ARB_IDLE;
                        owner_q    <= C_OWN_NONE;
                        pad_gnt_q  <= 1'b0;
                        wr_gnt_q   <= 1'b0;
                        rd_gnt_q   <= 1'b0;
                        beat_cnt_q <= '0;
                        rr_ptr_q   <= rr_next(owner_q);
                    end else begin
                        beat_cnt_q <= w_cnt_inc;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // SRAM port mux and read return
    // ------------------------------------------------------------------------
    assign sram_addr_d  = w_beat    ? w_own_addr : sram_addr_q;
    assign sram_wdata_d = w_wr_beat ? w_own_data : sram_wdata_q;
    // SRAM answers one cycle after the read beat, i.e. while rd_valid is high.
    assign rd_data_d    = rd_valid_q ? bus.sram_rdata : rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rd_data_q    <= '0;
        end else begin
            rd_valid_q   <= w_rd_beat;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign bus.sram_cen   = w_beat;
    assign bus.sram_wen   = w_wr_beat;
    assign bus.sram_addr  = sram_addr_d;
    assign bus.sram_wdata = sram_wdata_d;
    assign bus.rd_data    = rd_data_d;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.pad_gnt    = pad_gnt_q;
    assign bus.wr_gnt     = wr_gnt_q;
    assign bus.rd_gnt     = rd_gnt_q;
    assign bus.arb_owner  = owner_q;

endmodule
`default_nettype wire
